// File: rtl/mem_responder.sv
// mem_responder: pipelined memory responder with processor read/write ports and a preload port.
// Define MEM_RESPONDER_OOB_ERR_EN to add mem_oob_err flagging out-of-range accesses.
module mem_responder #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic [ADDR_W-1:0] mem_read_addr,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [ADDR_W-1:0] mem_read_data_addr,
    output logic              mem_read_valid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
`ifdef MEM_RESPONDER_OOB_ERR_EN
    ,
    output logic              mem_oob_err
`endif
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("mem_responder: READ_LATENCY must be in 1..8");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              rd_ok, wr_ok, ld_ok;
    logic [DATA_W-1:0] rd_word;

    assign rd_ok = {1'b0, mem_read_addr} < LIMIT;
    assign wr_ok = {1'b0, mem_write_addr} < LIMIT;
    assign ld_ok = {1'b0, load_addr} < LIMIT;

    // Load port is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (mem_we && wr_ok) mem_q[mem_write_addr[IDX_W-1:0]] <= mem_write_data;
        if (load_en && ld_ok) mem_q[load_addr[IDX_W-1:0]] <= load_data;
    end

    // Write-first lookup with full-width address compares so upper bits never alias.
    always_comb begin
        rd_word = !rd_ok                                 ? '0 :
                  (load_en && load_addr == mem_read_addr) ? load_data :
                  (mem_we && mem_write_addr == mem_read_addr) ? mem_write_data :
                  mem_q[mem_read_addr[IDX_W-1:0]];
    end

    logic [DATA_W-1:0]       data_d [READ_LATENCY];
    logic [DATA_W-1:0]       data_q [READ_LATENCY];
    logic [ADDR_W-1:0]       addr_d [READ_LATENCY];
    logic [ADDR_W-1:0]       addr_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_d, valid_q;

    always_comb begin
        data_d[0]  = rd_word;
        addr_d[0]  = mem_read_addr;
        valid_d[0] = 1'b1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            data_d[i]  = data_q[i-1];
            addr_d[i]  = addr_q[i-1];
            valid_d[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '{default: '0};
            addr_q  <= '{default: '0};
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign mem_read_data      = data_q[READ_LATENCY-1];
    assign mem_read_data_addr = addr_q[READ_LATENCY-1];
    assign mem_read_valid     = valid_q[READ_LATENCY-1];

`ifdef MEM_RESPONDER_OOB_ERR_EN
    logic [READ_LATENCY-1:0] oob_d, oob_q;
    logic                    wr_oob_d, wr_oob_q;

    always_comb begin
        oob_d[0] = !rd_ok;
        for (int i = 1; i < READ_LATENCY; i++) oob_d[i] = oob_q[i-1];
        wr_oob_d = (mem_we && !wr_ok) || (load_en && !ld_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oob_q    <= '0;
            wr_oob_q <= 1'b0;
        end else begin
            oob_q    <= oob_d;
            wr_oob_q <= wr_oob_d;
        end
    end

    assign mem_oob_err = oob_q[READ_LATENCY-1] | wr_oob_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table plus randomized traffic against a history-queue reference model,
// run on three instances with READ_LATENCY 1, 2 and 8.
module tb_mem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, ld = 1'b0;
    logic [15:0] wa = '0, wd = '0, la = '0, ldd = '0, ra = '0;
    logic [15:0] d1, d2, d8, a1, a2, a8;
    logic        v1, v2, v8, e1, e2, e8;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    mem_responder #(.READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_we(we), .mem_write_addr(wa), .mem_write_data(wd),
        .mem_read_addr(ra), .mem_read_data(d2), .mem_read_data_addr(a2), .mem_read_valid(v2),
        .load_en(ld), .load_addr(la), .load_data(ldd)
`ifdef MEM_RESPONDER_OOB_ERR_EN
        , .mem_oob_err(e2)
`endif
    );

    mem_responder #(.READ_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .mem_we(we), .mem_write_addr(wa), .mem_write_data(wd),
        .mem_read_addr(ra), .mem_read_data(d1), .mem_read_data_addr(a1), .mem_read_valid(v1),
        .load_en(ld), .load_addr(la), .load_data(ldd)
`ifdef MEM_RESPONDER_OOB_ERR_EN
        , .mem_oob_err(e1)
`endif
    );

    mem_responder #(.READ_LATENCY(8)) dut_l8 (
        .clk(clk), .rst(rst), .mem_we(we), .mem_write_addr(wa), .mem_write_data(wd),
        .mem_read_addr(ra), .mem_read_data(d8), .mem_read_data_addr(a8), .mem_read_valid(v8),
        .load_en(ld), .load_addr(la), .load_data(ldd)
`ifdef MEM_RESPONDER_OOB_ERR_EN
        , .mem_oob_err(e8)
`endif
    );

`ifndef MEM_RESPONDER_OOB_ERR_EN
    assign e1 = 1'b0;
    assign e2 = 1'b0;
    assign e8 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word array plus a history of every read result, newest last.
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        bit          known;
        bit          oob;
    } samp_t;

    samp_t       hist[$];
    logic [15:0] mm[DEPTH];
    bit          kn[DEPTH];
    bit          werr = 1'b0;

    always @(posedge clk) begin : model
        samp_t s;
        if (rst) begin
            s.a   = ra;
            s.oob = ra >= DEPTH;
            if (s.oob) begin
                s.d = '0; s.known = 1'b1;
            end else if (ld && la == ra) begin
                s.d = ldd; s.known = 1'b1;
            end else if (we && wa == ra) begin
                s.d = wd; s.known = 1'b1;
            end else begin
                s.d = mm[ra[7:0]]; s.known = kn[ra[7:0]];
            end
            hist.push_back(s);
            if (hist.size() > 8) void'(hist.pop_front());
            werr = (we && wa >= DEPTH) || (ld && la >= DEPTH);
        end else begin
            werr = 1'b0;
        end
        if (we && wa < DEPTH) begin
            mm[wa[7:0]] = wd; kn[wa[7:0]] = 1'b1;
        end
        if (ld && la < DEPTH) begin
            mm[la[7:0]] = ldd; kn[la[7:0]] = 1'b1;
        end
    end

    always @(negedge rst) begin
        hist.delete();
        werr = 1'b0;
    end

    task automatic cmp(input string nm, input int lat, input logic v, input logic [15:0] a,
                       input logic [15:0] d, input logic e);
        samp_t s;
        if (hist.size() >= lat) begin
            s = hist[hist.size() - lat];
            chk({nm, " valid"}, 32'(v), 32'd1);
            chk({nm, " addr"}, 32'(a), 32'(s.a));
            if (s.known) chk({nm, " data"}, 32'(d), 32'(s.d));
`ifdef MEM_RESPONDER_OOB_ERR_EN
            chk({nm, " err"}, 32'(e), 32'(s.oob | werr));
`endif
        end else begin
            chk({nm, " idle"}, {15'(0), v, a}, 32'd0);
            chk({nm, " idle data"}, 32'(d), 32'd0);
`ifdef MEM_RESPONDER_OOB_ERR_EN
            chk({nm, " idle err"}, 32'(e), 32'(werr));
`endif
        end
    endtask

    always @(negedge clk) begin
        cmp("model l1", 1, v1, a1, d1, e1);
        cmp("model l2", 2, v2, a2, d2, e2);
        cmp("model l8", 8, v8, a8, d8, e8);
    end

    typedef struct {
        string       nm;
        logic        we;
        logic [15:0] wa, wd;
        logic        ld;
        logic [15:0] la, ldd, ra;
        bit          chk;
        logic        v;
        logic [15:0] a, d;
        logic        e;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic w, input logic [15:0] wa_i, wd_i,
                                input logic l, input logic [15:0] la_i, ld_i, ra_i, input bit c,
                                input logic v, input logic [15:0] a, d, input logic e);
        vec_t x;
        x.nm = nm; x.we = w; x.wa = wa_i; x.wd = wd_i; x.ld = l; x.la = la_i; x.ldd = ld_i;
        x.ra = ra_i; x.chk = c; x.v = v; x.a = a; x.d = d; x.e = e;
        return x;
    endfunction

    function automatic logic [15:0] pick();
        int r = $urandom_range(0, 9);
        return r < 6 ? 16'($urandom_range(0, 7)) :
               r < 9 ? 16'($urandom_range(8, 255)) : 16'($urandom_range(256, 65535));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        tv.push_back(mk("ld0",    0, 0, 0,          1, 0, 16'h0312, 16'h00FF, 0, 0, 0, 0, 0));
        tv.push_back(mk("ld1",    0, 0, 0,          1, 1, 16'h0104, 16'h0000, 0, 0, 0, 0, 0));
        tv.push_back(mk("rd0",    0, 0, 0,          0, 0, 0,        16'h0001, 1, 1, 16'h0000, 16'h0312, 0));
        tv.push_back(mk("rd1",    0, 0, 0,          0, 0, 0,        16'h0000, 1, 1, 16'h0001, 16'h0104, 0));
        tv.push_back(mk("rd0b",   0, 0, 0,          0, 0, 0,        16'h0100, 1, 1, 16'h0000, 16'h0312, 0));
        tv.push_back(mk("oobrd",  1, 7, 16'hBEEF,   0, 0, 0,        16'h0007, 1, 1, 16'h0100, 16'h0000, 1));
        tv.push_back(mk("wrfst",  1, 7, 16'h2222,   1, 7, 16'h1111, 16'h0007, 1, 1, 16'h0007, 16'hBEEF, 0));
        tv.push_back(mk("ldwin",  1, 16'h0100, 16'hAAAA, 0, 0, 0,   16'h0000, 1, 1, 16'h0007, 16'h1111, 1));
        tv.push_back(mk("noalias",0, 0, 0,          0, 0, 0,        16'h0007, 1, 1, 16'h0000, 16'h0312, 0));
        tv.push_back(mk("rd7",    0, 0, 0,          0, 0, 0,        16'h0000, 1, 1, 16'h0007, 16'h1111, 0));
        tv.push_back(mk("rd0c",   0, 0, 0,          0, 0, 0,        16'h0000, 1, 1, 16'h0000, 16'h0312, 0));

        #1 rst = 1'b0;
        ra = 16'h0005;
        repeat (2) @(negedge clk);
        chk("reset valid l2", 32'(v2), 32'd0);
        chk("reset addr l2", 32'(a2), 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("release edge1 valid l2", 32'(v2), 32'd0);
        chk("release edge1 valid l8", 32'(v8), 32'd0);
        chk("release edge1 addr l1", {15'(0), v1, a1}, {16'd1, 16'h0005});
        @(negedge clk);
        chk("release edge2 l2", {15'(0), v2, a2}, {16'd1, 16'h0005});

        for (int i = 0; i < DEPTH; i++) begin
            ld = 1'b1; la = 16'(i); ldd = 16'($urandom); ra = 16'($urandom_range(0, 300));
            @(negedge clk);
        end
        ld = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            we = tv[i].we; wa = tv[i].wa; wd = tv[i].wd;
            ld = tv[i].ld; la = tv[i].la; ldd = tv[i].ldd; ra = tv[i].ra;
            @(negedge clk);
            if (tv[i].chk) begin
                chk({"tbl ", tv[i].nm, " valid"}, 32'(v2), 32'(tv[i].v));
                chk({"tbl ", tv[i].nm, " addr"}, 32'(a2), 32'(tv[i].a));
                chk({"tbl ", tv[i].nm, " data"}, 32'(d2), 32'(tv[i].d));
`ifdef MEM_RESPONDER_OOB_ERR_EN
                chk({"tbl ", tv[i].nm, " err"}, 32'(e2), 32'(tv[i].e));
`endif
            end
        end
        we = 1'b0; ld = 1'b0;

        // Asynchronous reset with reads in flight, then confirm contents survived.
        ra = 16'h0000;
        @(negedge clk);
        ra = 16'h0001;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async l2", {15'(0), v2, a2}, 32'd0);
        chk("async l2 data", 32'(d2), 32'd0);
        chk("async l8", {15'(0), v8, a8}, 32'd0);
        chk("async l1", {15'(0), v1, a1}, 32'd0);
        ra = 16'h0000;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("no stale l2", 32'(v2), 32'd0);
        chk("no stale l8", 32'(v8), 32'd0);
        chk("retained l1", {v1, a1, d1}, {1'b1, 16'h0000, 16'h0312});
        ra = 16'h0001;
        @(negedge clk);
        chk("retained l2", {v2, a2, d2}, {1'b1, 16'h0000, 16'h0312});
        chk("retained l1 addr1", {v1, a1, d1}, {1'b1, 16'h0001, 16'h0104});

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1 chk("random async l2", 32'(v2), 32'd0);
                @(negedge clk);
                #2 rst = 1'b1;
            end
            we = $urandom_range(0, 2) == 0; wa = pick(); wd = 16'($urandom);
            ld = $urandom_range(0, 3) == 0; la = pick(); ldd = 16'($urandom);
            ra = pick();
            @(negedge clk);
        end
        we = 1'b0; ld = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
